// File: rtl/pbp_pkg.sv
// Shared types and default sizing for the PBP serial match path.
package pbp_pkg;
  localparam int PBP_CODE_WIDTH = 8;
  localparam int PBP_GAP        = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} pbp_state_t;
endpackage

// File: rtl/pbp_piso_reg.sv
// Parallel-in serial-out register with zero fill, so the output settles to 0
// once every bit has left. Bit order follows SERIAL_LSB_FIRST_EN.
module pbp_piso_reg
  import pbp_pkg::*;
#(
  parameter int WIDTH = PBP_CODE_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);
  logic [WIDTH-1:0] q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     q <= '0;
    else if (load)  q <= din;
`ifdef SERIAL_LSB_FIRST_EN
    else if (shift) q <= q >> 1;
`else
    else if (shift) q <= q << 1;
`endif
  end

`ifdef SERIAL_LSB_FIRST_EN
  assign sout = q[0];
`else
  assign sout = q[WIDTH-1];
`endif
endmodule

// File: rtl/pbp_serial_loader.sv
// Captures ENTRY/KEY on START and streams them on X/Y as a fixed-length frame.
// SERIAL_LSB_FIRST_EN selects LSB-first bit order (default MSB-first).
module pbp_serial_loader
  import pbp_pkg::*;
#(
  parameter int WIDTH = PBP_CODE_WIDTH,
  parameter int GAP   = PBP_GAP
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] ENTRY,
  input  logic [WIDTH-1:0] KEY,
  output logic             X,
  output logic             Y,
  output logic             FRAME,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH + GAP + 1);
  localparam logic [CW-1:0] LAST  = CW'(WIDTH + GAP - 1);
  localparam logic [CW-1:0] WLAST = CW'(WIDTH - 1);

  pbp_state_t    state;
  logic [CW-1:0] cnt, cnt_nx;
  logic          load, shift;

  assign cnt_nx = cnt + CW'(1);
  assign load   = (state == ST_IDLE) && START;
  assign shift  = (state == ST_SHIFT);

  pbp_piso_reg #(.WIDTH(WIDTH)) u_entry (
    .CLK(CLK), .RST_N(RST_N), .load(load), .shift(shift), .din(ENTRY), .sout(X)
  );
  pbp_piso_reg #(.WIDTH(WIDTH)) u_key (
    .CLK(CLK), .RST_N(RST_N), .load(load), .shift(shift), .din(KEY), .sout(Y)
  );

  // cnt is the index of the current frame cycle; DONE is set one edge early
  // so it is registered and lands on index LAST.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      cnt   <= '0;
      FRAME <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          FRAME <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          if (START) begin
            state <= ST_SHIFT;
            cnt   <= '0;
            FRAME <= 1'b1;
            BUSY  <= 1'b1;
            DONE  <= (LAST == '0);
          end
        end
        default: begin
          FRAME <= 1'b0;
          if (cnt == LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
          end else begin
            cnt   <= cnt_nx;
            DONE  <= (cnt_nx == LAST);
            state <= (cnt >= WLAST) ? ST_GAP : ST_SHIFT;
          end
        end
      endcase
    end
  end
endmodule
